// File: rtl/proc_ctrl_fsm_if.sv
// Control-unit interface for the four-register processor.
// Groups the instruction fetch, flag input, and all datapath strobes
// between proc_ctrl_fsm (master) and the datapath/memories (slave).
//   instr       : instruction memory read data at pc (combinational read)
//   flags_in    : latched ALU flags, bit0 = Z, bit1 = C
//   pc, ir, opo : instruction address, instruction register, ir[7:4]
//   bus_sel     : BUS1 source (0-3 regs, 4 ALU, 5 RAM, 6 imm, 7 zero)
//   reg_we      : one-hot register write enable from BUS1
//   alu_a_ld, alu_op, flags_ld : ALU operand latch, function, flag load
//   ram_addr_ld, ram_we        : RAM address latch and write strobe
//   halted, state              : halt indicator and debug state
interface proc_ctrl_fsm_if;
  logic [7:0] instr;
  logic [7:0] flags_in;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [3:0] opo;
  logic [2:0] bus_sel;
  logic [3:0] reg_we;
  logic       alu_a_ld;
  logic [3:0] alu_op;
  logic       flags_ld;
  logic       ram_addr_ld;
  logic       ram_we;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  instr, flags_in,
    output pc, ir, opo, bus_sel, reg_we, alu_a_ld, alu_op, flags_ld,
           ram_addr_ld, ram_we, halted, state
  );

  modport slave (
    output instr, flags_in,
    input  pc, ir, opo, bus_sel, reg_we, alu_a_ld, alu_op, flags_ld,
           ram_addr_ld, ram_we, halted, state
  );
endinterface

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit, four-register processor.
// Fetches from instruction memory, decodes the 4-bit opcode and sequences
// BUS1, register write enables, the ALU operand latch and RAM strobes.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : proc_ctrl_fsm_if.master (instr/flags_in in, all strobes out)
// Parameter:
//   RESET_PC : pc value loaded on reset
module proc_ctrl_fsm #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  proc_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXA    = 3'd2,
    S_EXB    = 3'd3,
    S_WB     = 3'd4,
    S_IMM    = 3'd5,
    S_MEM    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t     state_q;
  logic       phase_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic       halted_q;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] rd_oh;
  logic [7:0] pc_inc;
  logic       unused_flags;

  assign op     = ir_q[7:4];
  assign rd     = ir_q[3:2];
  assign rs     = ir_q[1:0];
  assign rd_oh  = 4'b0001 << rd;
  assign pc_inc = pc_q + 8'd1;
  assign unused_flags = ^bus.flags_in[7:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      phase_q  <= 1'b0;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= bus.instr;
          pc_q    <= pc_inc;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            4'h0, 4'hE:                      state_q <= S_FETCH;
            4'h1:                            state_q <= S_WB;
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_q <= S_EXA;
            4'h8, 4'hB, 4'hC, 4'hD:          state_q <= S_IMM;
            4'h9, 4'hA:                      state_q <= S_MEM;
            default: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
          endcase
        end
        S_EXA: state_q <= S_EXB;
        S_EXB: state_q <= S_WB;
        S_WB:  state_q <= S_FETCH;
        S_IMM: begin
          // pc already points at the immediate byte; skip it unless a jump is taken
          case (op)
            4'hB:    pc_q <= bus.instr;
            4'hC:    pc_q <= bus.flags_in[0] ? bus.instr : pc_inc;
            4'hD:    pc_q <= bus.flags_in[1] ? bus.instr : pc_inc;
            default: pc_q <= pc_inc;
          endcase
          state_q <= S_FETCH;
        end
        S_MEM: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Strobes decoded from state, phase and ir; only one write source per state
  always_comb begin
    bus.bus_sel     = 3'd7;
    bus.reg_we      = '0;
    bus.alu_a_ld    = 1'b0;
    bus.alu_op      = '0;
    bus.flags_ld    = 1'b0;
    bus.ram_addr_ld = 1'b0;
    bus.ram_we      = 1'b0;
    case (state_q)
      S_EXA: begin
        bus.bus_sel  = {1'b0, rd};
        bus.alu_a_ld = 1'b1;
      end
      S_EXB: begin
        bus.bus_sel  = {1'b0, rs};
        bus.alu_op   = op;
        bus.flags_ld = 1'b1;
      end
      S_WB: begin
        bus.reg_we = rd_oh;
        if (op == 4'h1) begin
          bus.bus_sel = {1'b0, rs};
        end else begin
          bus.bus_sel = 3'd4;
          bus.alu_op  = op;
        end
      end
      S_IMM: begin
        bus.bus_sel = 3'd6;
        if (op == 4'h8) bus.reg_we = rd_oh;
      end
      S_MEM: begin
        if (!phase_q) begin
          bus.bus_sel     = {1'b0, rs};
          bus.ram_addr_ld = 1'b1;
        end else if (op == 4'h9) begin
          bus.bus_sel = 3'd5;
          bus.reg_we  = rd_oh;
        end else begin
          bus.bus_sel = {1'b0, rd};
          bus.ram_we  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc     = pc_q;
  assign bus.ir     = ir_q;
  assign bus.opo    = ir_q[7:4];
  assign bus.halted = halted_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
module tb_proc_ctrl_fsm;

  localparam logic [7:0] RST_PC = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proc_ctrl_fsm_if bus ();

  proc_ctrl_fsm #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] flags;

  always_comb begin
    bus.instr    = mem[bus.pc];
    bus.flags_in = flags;
  end

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [3:0] opo;
    logic [2:0] bsel;
    logic [3:0] we;
    logic       aa;
    logic [3:0] aop;
    logic       fl;
    logic       ral;
    logic       rwe;
    logic       hl;
  } obs_t;

  obs_t exp_q[$];
  bit   active = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t mk(input logic [2:0] st, input logic [7:0] p, input logic [7:0] ir);
    obs_t r;
    r      = '0;
    r.st   = st;
    r.pc   = p;
    r.ir   = ir;
    r.opo  = ir[7:4];
    r.bsel = 3'd7;
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t r;
    r.st   = bus.state;
    r.pc   = bus.pc;
    r.ir   = bus.ir;
    r.opo  = bus.opo;
    r.bsel = bus.bus_sel;
    r.we   = bus.reg_we;
    r.aa   = bus.alu_a_ld;
    r.aop  = bus.alu_op;
    r.fl   = bus.flags_ld;
    r.ral  = bus.ram_addr_ld;
    r.rwe  = bus.ram_we;
    r.hl   = bus.halted;
    return r;
  endfunction

  task automatic check(input string nm, input obs_t a, input obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got st=%0d pc=%h ir=%h opo=%h bsel=%0d we=%b aa=%b aop=%h fl=%b ral=%b rwe=%b hl=%b | want st=%0d pc=%h ir=%h opo=%h bsel=%0d we=%b aa=%b aop=%h fl=%b ral=%b rwe=%b hl=%b",
               nm, a.st, a.pc, a.ir, a.opo, a.bsel, a.we, a.aa, a.aop, a.fl, a.ral, a.rwe, a.hl,
               e.st, e.pc, e.ir, e.opo, e.bsel, e.we, e.aa, e.aop, e.fl, e.ral, e.rwe, e.hl);
    end
  endtask

  // Instruction-level reference: expands each instruction into the per-cycle
  // observable outputs implied by the ISA timing table.
  task automatic model_run(input int ncyc, input logic [7:0] f);
    obs_t       q[$];
    obs_t       r;
    logic [7:0] p, ir, imm;
    logic [3:0] op, oh;
    logic [1:0] rd, rs;
    bit         taken;
    p  = RST_PC;
    ir = 8'h00;
    while (q.size() < ncyc) begin
      q.push_back(mk(3'd0, p, ir));
      ir = mem[p];
      p  = p + 8'd1;
      op = ir[7:4];
      rd = ir[3:2];
      rs = ir[1:0];
      oh = 4'b0001 << rd;
      q.push_back(mk(3'd1, p, ir));
      case (op)
        4'h0, 4'hE: ;
        4'h1: begin
          r = mk(3'd4, p, ir); r.bsel = {1'b0, rs}; r.we = oh; q.push_back(r);
        end
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
          r = mk(3'd2, p, ir); r.bsel = {1'b0, rd}; r.aa = 1'b1; q.push_back(r);
          r = mk(3'd3, p, ir); r.bsel = {1'b0, rs}; r.aop = op; r.fl = 1'b1; q.push_back(r);
          r = mk(3'd4, p, ir); r.bsel = 3'd4; r.aop = op; r.we = oh; q.push_back(r);
        end
        4'h8, 4'hB, 4'hC, 4'hD: begin
          imm = mem[p];
          r = mk(3'd5, p, ir); r.bsel = 3'd6;
          if (op == 4'h8) r.we = oh;
          q.push_back(r);
          taken = (op == 4'hB) || (op == 4'hC && f[0]) || (op == 4'hD && f[1]);
          p = taken ? imm : p + 8'd1;
        end
        4'h9, 4'hA: begin
          r = mk(3'd6, p, ir); r.bsel = {1'b0, rs}; r.ral = 1'b1; q.push_back(r);
          r = mk(3'd6, p, ir);
          if (op == 4'h9) begin r.bsel = 3'd5; r.we = oh; end
          else begin r.bsel = {1'b0, rd}; r.rwe = 1'b1; end
          q.push_back(r);
        end
        default: begin
          while (q.size() < ncyc) begin
            r = mk(3'd7, p, ir); r.hl = 1'b1; q.push_back(r);
          end
        end
      endcase
    end
    for (int i = 0; i < ncyc; i++) exp_q.push_back(q[i]);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic run_prog(input string nm, input int ncyc);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check({nm, "/reset"}, observe(), mk(3'd0, RST_PC, 8'h00));
    model_run(ncyc, flags);
    @(posedge clk);
    #1 rst = 1'b0;
    active = 1'b1;
    for (int i = 0; i < ncyc + 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s/drain: %0d expected cycles left unchecked, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    active = 1'b0;
  endtask

  always @(negedge clk) begin
    if (active && exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check("cycle", observe(), e);
    end
  end

  initial begin
    obs_t e;
    clear_mem();
    flags = 8'h00;
    rst   = 1'b0;
    #1 rst = 1'b1;

    run_prog("nop", 10);

    clear_mem();
    mem[0] = 8'h88; mem[1] = 8'h5A; mem[2] = 8'h12;
    run_prog("ldi_mov", 10);

    clear_mem();
    mem[0] = 8'h27;
    run_prog("add", 9);

    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h40;
    flags = 8'h01;
    run_prog("jz_taken", 7);
    flags = 8'h00;
    run_prog("jz_not", 7);
    flags = 8'h02;
    mem[0] = 8'hD0;
    run_prog("jc_taken", 7);

    clear_mem();
    mem[0] = 8'hA6; mem[1] = 8'h96;
    run_prog("st_ld", 10);

    clear_mem();
    mem[0] = 8'hB0; mem[1] = 8'hFE;
    mem[8'hFE] = 8'hB0; mem[8'hFF] = 8'h10;
    mem[8'h10] = 8'hF0;
    run_prog("jmp_wrap", 14);

    clear_mem();
    mem[0] = 8'hB0; mem[1] = 8'hFE;
    mem[8'hFE] = 8'h84; mem[8'hFF] = 8'h77;
    run_prog("ldi_wrap", 12);

    clear_mem();
    mem[0] = 8'hF0;
    run_prog("hlt", 10);

    // Reset landing in EXB of an ALU op must abort before the WB write
    clear_mem();
    mem[0] = 8'h27;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = mk(3'd3, 8'h01, 8'h27); e.bsel = 3'd3; e.aop = 4'h2; e.fl = 1'b1;
    check("exb_before_reset", observe(), e);
    #1 rst = 1'b1;
    @(negedge clk);
    check("exb_reset", observe(), mk(3'd0, RST_PC, 8'h00));
    @(negedge clk);
    check("exb_reset_hold", observe(), mk(3'd0, RST_PC, 8'h00));

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      flags = 8'($urandom);
      run_prog("random", 150);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Multi-cycle control unit for the 8-bit, four-register processor. It fetches instructions from instruction memory, decodes the 4-bit opcode and sequences the shared BUS1, register file write enables, ALU operand latch and data RAM strobes. It sits between instruction memory and the existing datapath, and it drives the opcode observation port `opo`.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `instr`  in  8  instruction memory read data at `pc` (combinational read).
- `flags_in`  in  8  latched ALU flags; bit0 = Z, bit1 = C.
- `pc`  out  8  instruction address, registered.
- `ir`  out  8  instruction register: [7:4] opcode, [3:2] rd, [1:0] rs.
- `opo`  out  4  `ir[7:4]`.
- `bus_sel`  out  3  BUS1 source: 0–3 = R0–R3, 4 = ALU result, 5 = RAM data, 6 = `instr` (immediate), 7 = zero.
- `reg_we`  out  4  one-hot register write enable, loads the register from BUS1.
- `alu_a_ld`  out  1  latches ALU operand A from BUS1.
- `alu_op`  out  4  ALU function; equals the opcode during ALU states, else 0.
- `flags_ld`  out  1  ALU flag register load.
- `ram_addr_ld`  out  1  latches the RAM address register from BUS1.
- `ram_we`  out  1  RAM write of BUS1 at the latched address.
- `halted`  out  1  high in HALT.
- `state`  out  3  current state encoding, for debug.

## Operation
- Opcodes: 0 NOP, 1 MOV rd←rs, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT (rd←op(rd,rs)), 8 LDI rd←imm, 9 LD rd←RAM[rs], A ST RAM[rs]←rd, B JMP imm, C JZ imm, D JC imm, E reserved (executes as NOP), F HLT.
- An immediate is the byte after the opcode byte. It is read from `instr` at the incremented `pc`.
- States: FETCH(0), DECODE(1), EXA(2), EXB(3), WB(4), IMM(5), MEM(6), HALT(7).
- FETCH: `ir`←`instr`, `pc`←`pc`+1. Next state is DECODE.
- DECODE: no strobes. Next state by opcode: NOP/E → FETCH; MOV → WB; 2–7 → EXA; 8, B, C, D → IMM; 9, A → MEM; F → HALT.
- EXA: `bus_sel`=rd, `alu_a_ld`=1. Next state is EXB.
- EXB: `bus_sel`=rs, `alu_op`=opcode, `flags_ld`=1. Next state is WB.
- WB: for MOV, `bus_sel`=rs; for ALU ops, `bus_sel`=4 and `alu_op` is held. `reg_we[rd]`=1. Next state is FETCH.
- IMM: `bus_sel`=6.
  - LDI: `reg_we[rd]`=1, `pc`←`pc`+1.
  - JMP: `pc`←`instr`.
  - JZ: `pc`←`instr` if `flags_in[0]`, else `pc`+1.
  - JC: `pc`←`instr` if `flags_in[1]`, else `pc`+1.
  - Next state is FETCH.
- MEM: two cycles, tracked by an internal phase bit.
  - Phase 0: `bus_sel`=rs, `ram_addr_ld`=1.
  - Phase 1, LD: `bus_sel`=5, `reg_we[rd]`=1.
  - Phase 1, ST: `bus_sel`=rd, `ram_we`=1.
  - After phase 1, next state is FETCH.
- HALT: absorbing state. All strobes are 0, `bus_sel`=7, `halted`=1. Only `rst` leaves it.
- Strobes are decoded combinationally from state, phase and `ir`. At most one `reg_we` bit is high. `ram_we` and `reg_we` are never high together.
- PC arithmetic is modulo 256: 8'hFF+1 = 8'h00. An immediate fetched at 8'hFF wraps `pc` to 8'h00.

## Timing
- Reset (asynchronous): `pc`=`RESET_PC`, `ir`=0, state=FETCH, phase=0, `halted`=0, all strobes 0, `alu_op`=0.
- The FETCH-state decode is active in the cycle after `rst` deasserts.
- Cycles per instruction, FETCH to the next FETCH:
  - NOP/E: 2
  - MOV, LDI, JMP/JZ/JC: 3
  - LD/ST: 4
  - ALU: 5
- HLT reaches HALT in 2 cycles.
- Register writes and RAM writes take effect at the rising edge ending WB, IMM or MEM phase 1.
- JZ and JC sample `flags_in` during IMM, so flags from any earlier ALU instruction are valid.
- Reset asserted mid-instruction aborts immediately. A write strobe that is high in that cycle is dropped.

## Test plan
- Reset/NOP: hold `rst` 50 ns, release, feed 8'h00. Required: `pc` 0→1→2 every 2 cycles, strobes always 0.
- LDI R2,#5A then MOV R0,R2: program 8'h88,8'h5A,8'h12. Required: IMM cycle shows `bus_sel`=6, `reg_we`=4'b0100; WB shows `bus_sel`=2, `reg_we`=4'b0001; `pc`=3.
- ADD R1,R3 (8'h27): EXA has `bus_sel`=1, `alu_a_ld`; EXB has `bus_sel`=3, `alu_op`=2, `flags_ld`; WB has `bus_sel`=4, `reg_we`=4'b0010. Total 5 cycles.
- JZ 8'h40 with `flags_in`=8'h01, then again with 8'h00: `pc` becomes 8'h40, then `pc` becomes 8'h02.
- ST/LD: 8'hA6 (RAM[R2]←R1) yields `ram_addr_ld` with `bus_sel`=2, then `ram_we` with `bus_sel`=1. 8'h96 yields `bus_sel`=5 with `reg_we`=4'b0010.
- Edges: JMP at `pc`=8'hFE with imm at 8'hFF loads the target. HLT (8'hF0) sets `halted` and freezes `pc`. Asserting `rst` during ALU EXB returns to FETCH with `pc`=0 and no `reg_we` pulse.
